// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one outstanding request, registered response.
// Optional alignment trap compiled in with `define DMEM_UNALIGNED_TRAP_EN.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    mis_q, mis_d;

  logic                    load_ok_q;
  logic                    err_q;
  logic [31:0]             rd_word_q;

  logic                    accept;
  logic                    enter_resp;
  logic                    req_mis;
  logic                    acc_we;
  logic                    acc_mis;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic                    do_write;

  logic [31:0]             mem [DEPTH];

  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

`ifdef DMEM_UNALIGNED_TRAP_EN
  assign req_mis = (req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid && req_ready;

  // With zero wait states the access completes on the accepting edge, so the
  // live request fields are used instead of the (not yet loaded) latches.
  assign acc_we    = (state_q == IDLE) ? req_we                           : we_q;
  assign acc_idx   = (state_q == IDLE) ? req_addr[DEPTH_LOG2+1:2]         : idx_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata                        : wdata_q;
  assign acc_mis   = (state_q == IDLE) ? req_mis                          : mis_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    mis_d      = mis_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          idx_d   = req_addr[DEPTH_LOG2+1:2];
          wdata_d = req_wdata;
          mis_d   = req_mis;
          cnt_d   = WAIT_CNT;
          if (WAIT_CNT == 4'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
    end
  end

  // Gated by rst so an access aborted in WAIT never reaches storage.
  assign do_write = enter_resp && acc_we && !acc_mis && !rst;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp) begin
      rd_word_q <= mem[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (enter_resp) begin
      load_ok_q <= !acc_we && !acc_mis;
      err_q     <= acc_mis;
    end else if ((state_q == RESP) && resp_ready) begin
      load_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end
  end

  assign resp_rdata = load_ok_q ? rd_word_q : 32'd0;
  assign resp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, giving the log2 of the word count of the internal storage (256 x 32-bit words).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted per access (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the CPU is presenting a data-memory request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: the byte address (the CPU ALU result).
REQ-009 The block SHALL have port req_wdata, input, 32 bits: the store data (the CPU rt register value).
REQ-010 The block SHALL have port resp_valid, output, 1 bit: a response is available.
REQ-011 The block SHALL have port resp_ready, input, 1 bit: the CPU accepts the response.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: the load data; it is 0 for stores and for errors.
REQ-013 The block SHALL have port resp_err, output, 1 bit: the access was rejected (see Configuration).

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-015 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-016 A request SHALL be accepted at the edge where req_valid and req_ready are both 1; at that edge the block latches req_we, req_addr and req_wdata and loads the wait counter with WAIT_CYCLES.
REQ-017 On acceptance, the next state SHALL be WAIT if WAIT_CYCLES is greater than 0, otherwise RESP.
REQ-018 In WAIT, the counter SHALL decrement once per cycle, and the FSM SHALL move to RESP at the edge where the counter equals 1.
REQ-019 resp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 The word index SHALL be latched addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so accesses alias modulo the depth.
REQ-021 A store SHALL commit to storage at the edge that enters RESP, never earlier.
REQ-022 A load SHALL capture storage[index] into resp_rdata at the edge that enters RESP.
REQ-023 In RESP, resp_valid, resp_rdata and resp_err SHALL remain stable until resp_ready is 1.
REQ-024 On the resp_valid & resp_ready handshake, the FSM SHALL return to IDLE, and resp_valid SHALL be 0 in the following cycle.
REQ-025 A request presented during the handshake cycle SHALL NOT be accepted; the earliest next acceptance is the first cycle back in IDLE.
REQ-026 resp_ready while resp_valid is 0 SHALL be ignored; req_valid while req_ready is 0 SHALL be ignored and SHALL have no side effects.
REQ-027 A load following a store to the same index SHALL return the stored value.

Reset
REQ-028 When rst is 1 at a rising edge, the block SHALL enter IDLE with the counter at 0, req_ready at 1, resp_valid at 0, resp_rdata at 0 and resp_err at 0.
REQ-029 Reset asserted in WAIT SHALL abort the access, and a pending store SHALL NOT be written.
REQ-030 Reset asserted in RESP SHALL drop the response; a store already committed remains in storage.
REQ-031 Storage contents SHALL NOT be initialised by reset.

Configuration
REQ-032 The alignment check SHALL be compiled in by defining the macro DMEM_UNALIGNED_TRAP_EN.
REQ-033 With DMEM_UNALIGNED_TRAP_EN defined, an accepted request with addr[1:0] not equal to 0 SHALL still take the full WAIT_CYCLES+1 latency, SHALL respond with resp_err at 1 and resp_rdata at 0, and SHALL perform no storage write.
REQ-034 Without DMEM_UNALIGNED_TRAP_EN, addr[1:0] SHALL be ignored, resp_err SHALL be tied to 0, and every access SHALL proceed normally.

Verification
REQ-035 The bench SHALL cover back-to-back store then load (WAIT_CYCLES=2): store 0xDEADBEEF to 0x10, then load 0x10 -> each resp_valid appears 3 cycles after acceptance, the load returns 0xDEADBEEF, and the store returns rdata 0.
REQ-036 The bench SHALL cover WAIT_CYCLES=0: load of a pre-stored word 0x12345678 -> resp_valid in the cycle immediately after acceptance, with the correct data.
REQ-037 The bench SHALL cover response backpressure: resp_ready held at 0 for 5 cycles -> resp_valid and data remain stable, req_ready stays 0, and a second req_valid is ignored until the handshake completes.
REQ-038 The bench SHALL cover aliasing with DEPTH_LOG2=8: store 0xA5A5A5A5 to 0x0000_0400, then load 0x0000_0000 -> returns 0xA5A5A5A5.
REQ-039 The bench SHALL cover reset mid-store: rst pulsed in WAIT during a store of 0x1 to 0x20 -> the FSM is in IDLE, resp_valid is 0, and a later load of 0x20 returns the prior value.
REQ-040 The bench SHALL cover misalignment: a store to 0x13 -> with DMEM_UNALIGNED_TRAP_EN defined, resp_err is 1 and word 0x10 is unchanged; without the macro, resp_err is 0 and word 0x10 is written.
